// File: rtl/pio_in_pkg.sv
// pio_in_pkg: register map and bus width shared by the input PIO
package pio_in_pkg;
   localparam int DATA_W = 32;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP = 2'd2;
   localparam logic [1:0] ADDR_EDGESEL = 2'd3;
endpackage

// File: rtl/input_debounce.sv
// input_debounce: one-bit two-flop synchroniser followed by a stability counter
module input_debounce #(
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_raw,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0]    sync_q, sync_d;
   logic          db_q, db_d, chg;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      sync_d = {sync_q[0], in_raw};
      chg    = sync_q[1] != db_q && cnt_q == LAST;
      db_d   = chg ? sync_q[1] : db_q;
      cnt_d  = (sync_q[1] == db_q || chg) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {2{IDLE_LEVEL}};
         db_q   <= IDLE_LEVEL;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         db_q   <= db_d;
         cnt_q  <= cnt_d;
      end
   end
   // strobes fire on the same edge the debounced level flips
   assign db_o   = db_q;
   assign rise_o = chg & sync_q[1];
   assign fall_o = chg & ~sync_q[1];
endmodule

// File: rtl/key_switch_pio_in.sv
// key_switch_pio_in: Avalon-MM input PIO with debounce, edge capture and level irq
module key_switch_pio_in
   import pio_in_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in_raw,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq
);
   logic [WIDTH-1:0]  data, rise, fall, wdata;
   logic [WIDTH-1:0]  mask_q, mask_d, cap_q, cap_d, sel_q, sel_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              irq_q, irq_d;
   logic              unused_wd;
   assign wdata     = avs_writedata[WIDTH-1:0];
   assign unused_wd = ^avs_writedata;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      input_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .IDLE_LEVEL     (IDLE_LEVEL[i])
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .in_raw(in_raw[i]),
         .db_o  (data[i]),
         .rise_o(rise[i]),
         .fall_o(fall[i])
      );
   end
   always_comb begin
      mask_d  = (avs_write && avs_address == ADDR_IRQMASK) ? wdata : mask_q;
      sel_d   = (avs_write && avs_address == ADDR_EDGESEL) ? wdata : sel_q;
      // set term is OR-ed last so a same-cycle capture beats the W1C
      cap_d   = (cap_q & ~((avs_write && avs_address == ADDR_EDGECAP) ? wdata : '0))
              | (rise & sel_q) | (fall & ~sel_q);
      irq_d   = |(cap_q & mask_q);
      rdata_d = !avs_read                    ? rdata_q         :
                avs_address == ADDR_DATA    ? DATA_W'(data)   :
                avs_address == ADDR_IRQMASK ? DATA_W'(mask_q) :
                avs_address == ADDR_EDGECAP ? DATA_W'(cap_q)  : DATA_W'(sel_q);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q  <= '0;
         cap_q   <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end
   assign avs_readdata = rdata_q;
   assign irq          = irq_q;
endmodule

// File: tb/tb_key_switch_pio_in.sv
// tb_key_switch_pio_in: directed stimulus checked against a stability-window model
module tb_key_switch_pio_in;
   localparam int W = 4;
   localparam int D = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [W-1:0] in_raw = 4'hF;
   logic [1:0]  avs_address = 2'd0;
   logic        avs_read = 1'b0, avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic [31:0] avs_readdata;
   logic        irq;
   int compared = 0, mismatched = 0;

   key_switch_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(4'b1111)) dut (
      .clk(clk), .reset(reset), .in_raw(in_raw), .avs_address(avs_address),
      .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_readdata(avs_readdata), .irq(irq));

   always #5 clk = ~clk;

   // model: a synchronised level is accepted once it has differed from the
   // accepted level for D consecutive cycles; rh[j] = raw sampled j+1 edges ago
   logic [W-1:0] rh [0:D];
   logic [W-1:0] m_db, m_cap, m_mask, m_sel, m_set, m_clr, m_dbn;
   logic [31:0]  m_rd;
   logic         m_irq, m_stable;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j <= D; j++) rh[j] = 4'hF;
         m_db = 4'hF; m_cap = 0; m_mask = 0; m_sel = 0; m_rd = 0; m_irq = 0;
      end else begin
         m_set = 0;
         m_dbn = m_db;
         for (int b = 0; b < W; b++) begin
            m_stable = 1'b1;
            for (int j = 1; j <= D; j++) if (rh[j][b] == m_db[b]) m_stable = 1'b0;
            if (m_stable) begin
               m_dbn[b] = ~m_db[b];
               if (m_dbn[b] == m_sel[b]) m_set[b] = 1'b1;
            end
         end
         m_clr = (avs_write && avs_address == 2'd2) ? avs_writedata[W-1:0] : '0;
         if (avs_read)
            m_rd = {28'd0, avs_address == 2'd0 ? m_db : avs_address == 2'd1 ? m_mask :
                           avs_address == 2'd2 ? m_cap : m_sel};
         m_irq = |(m_cap & m_mask);
         m_cap = (m_cap & ~m_clr) | m_set;
         if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[W-1:0];
         if (avs_write && avs_address == 2'd3) m_sel = avs_writedata[W-1:0];
         m_db = m_dbn;
         for (int j = D; j > 0; j--) rh[j] = rh[j-1];
         rh[0] = in_raw;
      end
   end

   always @(negedge clk) begin
      compared++;
      if (avs_readdata !== m_rd || irq !== m_irq) begin
         mismatched++;
         $display("FAIL model t=%0t readdata=%h irq=%b required readdata=%h irq=%b",
                  $time, avs_readdata, irq, m_rd, m_irq);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s got=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      chk(nm, avs_readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_irq", {31'd0, irq}, 32'd0);
      end
      rd(2'd0, 32'h0000000F, "reset_data");
      rd(2'd2, 32'h0, "reset_edgecap");
      rd(2'd1, 32'h0, "reset_irqmask");
      rd(2'd3, 32'h0, "reset_edgesel");
      // read and write in one cycle return the pre-write value; upper bits dropped
      avs_address = 2'd1; avs_writedata = 32'hFFFFFFF5; avs_read = 1'b1; avs_write = 1'b1;
      @(negedge clk);
      avs_read = 1'b0; avs_write = 1'b0;
      chk("rdwr_old", avs_readdata, 32'h0);
      rd(2'd1, 32'h5, "mask_upper_bits");
      wr(2'd1, 32'h0);
      wr(2'd0, 32'h0);
      rd(2'd0, 32'hF, "data_write_ignored");
      // short glitch is filtered
      in_raw = 4'hE; tick(3); in_raw = 4'hF; tick(10);
      rd(2'd0, 32'hF, "glitch_data");
      rd(2'd2, 32'h0, "glitch_edgecap");
      chk("glitch_irq", {31'd0, irq}, 32'd0);
      // falling edge on KEY0 with mask enabled
      wr(2'd1, 32'h1); wr(2'd3, 32'h0);
      in_raw = 4'hE; tick(5);
      rd(2'd0, 32'hF, "fall_data_edge4");
      chk("fall_irq_early", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'hE, "fall_data_edge5");
      chk("fall_irq_high", {31'd0, irq}, 32'd1);
      wr(2'd2, 32'h1);
      chk("w1c_irq_lag", {31'd0, irq}, 32'd1);
      tick(1);
      chk("w1c_irq_low", {31'd0, irq}, 32'd0);
      rd(2'd2, 32'h0, "w1c_edgecap");
      // rising-only capture on SW0, masked
      wr(2'd1, 32'h0); wr(2'd3, 32'h4);
      in_raw = 4'hA; tick(10);
      rd(2'd2, 32'h0, "sw0_fall_ignored");
      rd(2'd0, 32'hA, "sw0_low_data");
      in_raw = 4'hE; tick(10);
      rd(2'd2, 32'h4, "sw0_rise_captured");
      rd(2'd0, 32'hE, "sw0_high_data");
      chk("sw0_masked_irq", {31'd0, irq}, 32'd0);
      wr(2'd2, 32'h4);
      // W1C on the very edge bit 1 is captured: set wins
      in_raw = 4'hC; tick(5);
      wr(2'd2, 32'h2);
      rd(2'd2, 32'h2, "set_beats_clear");
      wr(2'd2, 32'h2);
      rd(2'd2, 32'h0, "later_clear");
      in_raw = 4'hF; tick(10);
      rd(2'd2, 32'h0, "rise_not_selected");
      // reset during bit-3 debounce
      wr(2'd1, 32'hF); wr(2'd3, 32'h0);
      in_raw = 4'h7; tick(2);
      reset = 1'b1; in_raw = 4'hF; tick(2);
      reset = 1'b0; tick(10);
      rd(2'd0, 32'hF, "rst_mid_data");
      rd(2'd2, 32'h0, "rst_mid_edgecap");
      rd(2'd1, 32'h0, "rst_mid_irqmask");
      chk("rst_mid_irq", {31'd0, irq}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
